// File: rtl/sa16_skew_feeder_if.sv
// Upstream row stream into the skew feeder: one activation row and one weight row per beat.
interface sa16_skew_feeder_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 16
);
    localparam int unsigned RW = LANES * WIDTH;

    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] in_act;
    logic [RW-1:0] in_weight;

    modport master (output in_valid, output in_act, output in_weight, input in_ready);
    modport slave  (input in_valid, input in_act, input in_weight, output in_ready);
endinterface

// File: rtl/sa16_skew_feeder.sv
// Operand feeder for the 16x16 systolic array: sequences one tile, skews lane i by i cycles,
// and drives the array accumulate-enable.
module sa16_skew_feeder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 16,
    parameter int unsigned KW    = 16,
    parameter int unsigned DRAIN = 31
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [KW-1:0]          k_len,
    output logic                   busy,
    output logic                   done,
    sa16_skew_feeder_if.slave      up,
    output logic [LANES*WIDTH-1:0] activation,
    output logic [LANES*WIDTH-1:0] weight,
    output logic                   control
);
    localparam int unsigned RW = LANES * WIDTH;
    localparam int unsigned DW = $clog2(DRAIN + 1);

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] klen_q, klen_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          busy_q, busy_d;
    logic          in_ready_q, in_ready_d;
    logic          done_q, done_d;
    logic          control_q, control_d;
    logic          accept_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            klen_q     <= '0;
            dcnt_q     <= '0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
            control_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            klen_q     <= klen_d;
            dcnt_q     <= dcnt_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
            control_q  <= control_d;
        end
    end

    // Status flags are computed from the next state so they line up with the state register.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        klen_d   = klen_q;
        dcnt_d   = dcnt_q;
        accept_c = (state_q == FEED) && in_ready_q && up.in_valid;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    klen_d  = k_len;
                    cnt_d   = '0;
                    state_d = (k_len == '0) ? DONE : FEED;
                end
            end
            FEED: begin
                if (accept_c) begin
                    cnt_d = cnt_q + KW'(1);
                    if (cnt_q == klen_q - KW'(1)) begin
                        state_d = FLUSH;
                        dcnt_d  = DW'(DRAIN - 1);
                    end
                end
            end
            FLUSH: begin
                if (dcnt_q == '0) state_d = DONE;
                else              dcnt_d  = dcnt_q - DW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d     = (state_d == FEED) || (state_d == FLUSH);
        in_ready_d = (state_d == FEED);
        done_d     = (state_d == DONE);
        control_d  = (state_q == FEED) || (state_q == FLUSH);
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign control     = control_q;
    assign up.in_ready = in_ready_q;

    // Lane i: input register plus i delay stages; non-accept cycles feed zeros.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] a_q [i+1];
        logic [WIDTH-1:0] a_d [i+1];
        logic [WIDTH-1:0] w_q [i+1];
        logic [WIDTH-1:0] w_d [i+1];

        always_comb begin
            a_d[0] = accept_c ? up.in_act[RW-1-i*WIDTH -: WIDTH]    : '0;
            w_d[0] = accept_c ? up.in_weight[RW-1-i*WIDTH -: WIDTH] : '0;
            for (int j = 1; j <= i; j++) begin
                a_d[j] = a_q[j-1];
                w_d[j] = w_q[j-1];
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                a_q <= '{default: '0};
                w_q <= '{default: '0};
            end else begin
                a_q <= a_d;
                w_q <= w_d;
            end
        end

        assign activation[RW-1-i*WIDTH -: WIDTH] = a_q[i];
        assign weight[RW-1-i*WIDTH -: WIDTH]     = w_q[i];
    end
endmodule

// File: tb/tb_sa16_skew_feeder.sv
// Bench for sa16_skew_feeder: tile table plus a per-cycle scoreboard of skewed lanes and status.
module tb_sa16_skew_feeder;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned LANES = 16;
    localparam int unsigned KW    = 16;
    localparam int unsigned DRAIN = 31;
    localparam int unsigned RW    = LANES * WIDTH;
    localparam int unsigned CW    = 2 * RW;
    localparam int          NONE  = 1 << 30;

    logic          clk;
    logic          rstn;
    logic          start;
    logic [KW-1:0] k_len;
    logic          busy;
    logic          done;
    logic          control;
    logic [RW-1:0] activation;
    logic [RW-1:0] weight;

    sa16_skew_feeder_if #(.WIDTH(WIDTH), .LANES(LANES)) up ();

    sa16_skew_feeder #(.WIDTH(WIDTH), .LANES(LANES), .KW(KW), .DRAIN(DRAIN)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .k_len      (k_len),
        .busy       (busy),
        .done       (done),
        .up         (up),
        .activation (activation),
        .weight     (weight),
        .control    (control)
    );

    typedef struct {
        int          k;
        int          npat;
        logic [63:0] pat;
        bit          hold;
        bit          fixed;
        int          exp_acc;
        int          exp_lat;
    } vec_t;

    typedef struct {
        int            t;
        logic [RW-1:0] a;
        logic [RW-1:0] w;
    } row_t;

    row_t exp_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    int   feed_lo = NONE, feed_hi = -10, flush_hi = -10, t_done = -10;
    int   acc_cnt = 0, done_cnt = 0, done_cyc = -1;

    logic [RW-1:0] ea, ew;
    logic [3:0]    es;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_win(input int lo, input int hi);
        return (cyc >= lo) && (cyc <= hi);
    endfunction

    function automatic bit vbit(input vec_t v, input int idx);
        return (idx < v.npat) ? v.pat[idx] : 1'b1;
    endfunction

    function automatic logic [RW-1:0] mkrow(input bit fixed, input int base);
        logic [RW-1:0] r;
        for (int i = 0; i < LANES; i++)
            r[RW-1-i*WIDTH -: WIDTH] = fixed ? WIDTH'(base + i) : WIDTH'($urandom);
        return r;
    endfunction

    task automatic clear_model();
        exp_q.delete();
        feed_lo  = NONE;
        feed_hi  = -10;
        flush_hi = -10;
        t_done   = -10;
    endtask

    // Scoreboard: lane i must show the row accepted at cycle t exactly at t+1+i, zero otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            ea = '0;
            ew = '0;
            while (exp_q.size() > 0 && exp_q[0].t + int'(LANES) < cyc) void'(exp_q.pop_front());
            foreach (exp_q[e])
                for (int i = 0; i < LANES; i++)
                    if (exp_q[e].t + 1 + i == cyc) begin
                        ea[RW-1-i*WIDTH -: WIDTH] = exp_q[e].a[RW-1-i*WIDTH -: WIDTH];
                        ew[RW-1-i*WIDTH -: WIDTH] = exp_q[e].w[RW-1-i*WIDTH -: WIDTH];
                    end
            es = {in_win(feed_lo, feed_hi), in_win(feed_lo, flush_hi),
                  cyc == t_done, in_win(feed_lo + 1, t_done)};
            chk("status{rdy,busy,done,ctl}", CW'({up.in_ready, busy, done, control}), CW'(es));
            chk("data{act,wt}", {activation, weight}, {ea, ew});
            if (up.in_valid && up.in_ready) acc_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
    end

    task automatic run_tile(input vec_t v, input int abort);
        int s;
        int l;
        int n;
        logic [RW-1:0] a, w;
        step();
        s        = cyc;
        start    = 1'b1;
        k_len    = KW'(v.k);
        up.in_valid  = 1'b1;
        up.in_act    = mkrow(1'b0, 0);
        up.in_weight = mkrow(1'b0, 0);
        acc_cnt  = 0;
        done_cnt = 0;
        done_cyc = -1;
        l = s;
        n = 0;
        for (int idx = 0; n < v.k; idx++)
            if (vbit(v, idx)) begin
                n++;
                l = s + 1 + idx;
            end
        if (v.k == 0) begin
            feed_lo = NONE; feed_hi = -10; flush_hi = -10; t_done = s + 1;
        end else begin
            feed_lo = s + 1; feed_hi = l; flush_hi = l + int'(DRAIN); t_done = l + int'(DRAIN) + 1;
        end
        while (cyc < t_done && !(abort > 0 && cyc >= s + abort)) begin
            step();
            start = v.hold;
            a = mkrow(v.fixed, 1);
            w = mkrow(v.fixed, 17);
            if (cyc <= l) begin
                up.in_valid = vbit(v, cyc - s - 1);
                up.in_act    = a;
                up.in_weight = w;
                if (up.in_valid) exp_q.push_back('{cyc, a, w});
            end else begin
                up.in_valid  = 1'b1;
                up.in_act    = mkrow(1'b0, 0);
                up.in_weight = mkrow(1'b0, 0);
            end
        end
        if (abort == 0) begin
            start       = 1'b0;
            up.in_valid = 1'b0;
            @(negedge clk);
            #1;
            chk($sformatf("accepts_k%0d", v.k), CW'(acc_cnt), CW'(v.exp_acc));
            chk($sformatf("done_latency_k%0d", v.k), CW'(done_cyc - s), CW'(v.exp_lat));
            chk($sformatf("done_pulses_k%0d", v.k), CW'(done_cnt), CW'(1));
        end
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        // k, npat, pattern (bit idx = beat offset), hold start, fixed rows, accepts, start->done
        tbl[0] = '{1,     0, 64'h0,  1'b0, 1'b1, 1,     33};
        tbl[1] = '{4,     6, 64'h35, 1'b0, 1'b0, 4,     38};
        tbl[2] = '{0,     0, 64'h0,  1'b0, 1'b0, 0,     1};
        tbl[3] = '{3,     0, 64'h0,  1'b1, 1'b0, 3,     35};
        tbl[4] = '{5,     8, 64'hA3, 1'b0, 1'b0, 5,     41};
        tbl[5] = '{2,     0, 64'h0,  1'b0, 1'b0, 2,     34};
        tbl[6] = '{65535, 0, 64'h0,  1'b0, 1'b0, 65535, 65567};

        rstn = 1'b0;
        start = 1'b0;
        k_len = '0;
        up.in_valid  = 1'b0;
        up.in_act    = '0;
        up.in_weight = '0;
        #12;
        chk("reset_state", CW'({activation, weight}), CW'(0));
        chk("reset_status", CW'({up.in_ready, busy, done, control}), CW'(0));
        step();
        rstn   = 1'b1;
        mon_en = 1'b1;
        repeat (2) step();

        for (int t = 0; t < 5; t++) run_tile(tbl[t], 0);

        // Async reset in FLUSH while lane-15 data is still in flight.
        rv = '{2, 0, 64'h0, 1'b0, 1'b0, 2, 34};
        run_tile(rv, 10);
        #2;
        mon_en = 1'b0;
        rstn   = 1'b0;
        #1;
        chk("async_rst_act", CW'(activation), CW'(0));
        chk("async_rst_wt", CW'(weight), CW'(0));
        chk("async_rst_status", CW'({up.in_ready, busy, done, control}), CW'(0));
        start = 1'b0;
        up.in_valid = 1'b0;
        clear_model();
        repeat (3) step();
        rstn = 1'b1;
        done_cnt = 0;
        mon_en = 1'b1;
        repeat (3) step();
        chk("no_done_after_rst", CW'(done_cnt), CW'(0));

        run_tile(tbl[5], 0);
        run_tile(tbl[6], 0);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end
endmodule
